soc_system_led_pio: RTL and testbench

SOC_SYSTEM_LED_PIO -- requirements
Module: soc_system_led_pio

---
 rtl/soc_system_led_pio.sv | 117 +++++++++++
 tb/tb_soc_system_led_pio.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_led_pio.sv
// Avalon-MM LED PIO with set/clear aliases and an optional per-bit blink engine.
// Define SOC_SYSTEM_LED_PIO_BLINK_EN to build the blink_mask/blink_period registers.
module soc_system_led_pio #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter int               PRESCALE_W  = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr_s;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_nxt_s;
    logic [WIDTH-1:0] blink_s;
    logic [31:0]      rd_s;
    logic             unused_bits_s;

    assign wr_s          = chipselect & ~write_n;
    assign unused_bits_s = ^writedata[31:WIDTH];

    // Next data value: direct write, OR-set alias or AND-NOT-clear alias.
    always_comb begin
        data_nxt_s = data_r;
        if (wr_s) begin
            case (address)
                3'd0:    data_nxt_s = writedata[WIDTH-1:0];
                3'd4:    data_nxt_s = data_r | writedata[WIDTH-1:0];
                3'd5:    data_nxt_s = data_r & ~writedata[WIDTH-1:0];
                default: data_nxt_s = data_r;
            endcase
        end else begin
            data_nxt_s = data_r;
        end
    end

    // Data register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r <= RESET_VALUE;
        end else begin
            data_r <= data_nxt_s;
        end
    end

`ifdef SOC_SYSTEM_LED_PIO_BLINK_EN
    logic [WIDTH-1:0]      mask_r;
    logic [PRESCALE_W-1:0] period_r;
    logic [PRESCALE_W-1:0] cnt_r;
    logic                  phase_r;

    // Blink mask register; independent of the prescaler.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_r <= {WIDTH{1'b0}};
        end else if (wr_s && (address == 3'd2)) begin
            mask_r <= writedata[WIDTH-1:0];
        end
    end

    // Period register and prescaler; a period write restarts the blink and beats a wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_r <= {PRESCALE_W{1'b0}};
            cnt_r    <= {PRESCALE_W{1'b0}};
            phase_r  <= 1'b0;
        end else if (wr_s && (address == 3'd3)) begin
            period_r <= writedata[PRESCALE_W-1:0];
            cnt_r    <= {PRESCALE_W{1'b0}};
            phase_r  <= 1'b0;
        end else if (period_r == {PRESCALE_W{1'b0}}) begin
            cnt_r    <= {PRESCALE_W{1'b0}};
            phase_r  <= 1'b0;
        end else if (cnt_r == period_r) begin
            cnt_r    <= {PRESCALE_W{1'b0}};
            phase_r  <= ~phase_r;
        end else begin
            cnt_r    <= cnt_r + PRESCALE_W'(1);
        end
    end

    assign blink_s = mask_r & {WIDTH{phase_r}};
`else
    assign blink_s = {WIDTH{1'b0}};
`endif

    // Read mux from the current address, regardless of chipselect.
    always_comb begin
        rd_s = 32'd0;
        case (address)
            3'd0:    rd_s = 32'(data_r);
`ifdef SOC_SYSTEM_LED_PIO_BLINK_EN
            3'd2:    rd_s = 32'(mask_r);
            3'd3:    rd_s = 32'(period_r);
`endif
            default: rd_s = 32'd0;
        endcase
    end

    // Registered read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= 32'd0;
        end else begin
            readdata <= rd_s;
        end
    end

    assign out_port = data_r ^ blink_s;

endmodule

// File: tb/tb_soc_system_led_pio.sv
// Directed self-checking bench for soc_system_led_pio (RESET_VALUE = 8'hA5).
// Blink scenarios run when SOC_SYSTEM_LED_PIO_BLINK_EN is defined, otherwise the disabled-feature checks run.
module tb_soc_system_led_pio;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_checks;
    int n_fail;

    soc_system_led_pio #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5),
        .PRESCALE_W  (24)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write captured at the next rising edge; returns 1 time unit after that edge.
    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Present an address; readdata is valid 1 time unit after the next rising edge.
    task automatic do_read(input logic [2:0] a);
        @(negedge clk);
        address = a;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        #3;
        n_checks++;
        if (out_port !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_out_port: got %h expected a5", out_port);
        end
        n_checks++;
        if (readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_readdata: got %h expected 00000000", readdata);
        end
        #9;
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (readdata !== 32'h0000_00A5) begin
            n_fail++;
            $display("FAIL reset_read_addr0: got %h expected 000000a5", readdata);
        end
        n_checks++;
        if (out_port !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_release_out_port: got %h expected a5", out_port);
        end
    endtask

    task automatic test_set_clear;
        do_write(3'd0, 32'h0000_000F);
        n_checks++;
        if (out_port !== 8'h0F) begin
            n_fail++;
            $display("FAIL write_data: got %h expected 0f", out_port);
        end
        do_write(3'd4, 32'hFFFF_FFF0);
        n_checks++;
        if (out_port !== 8'hFF) begin
            n_fail++;
            $display("FAIL outset: got %h expected ff", out_port);
        end
        do_write(3'd5, 32'h0000_0081);
        n_checks++;
        if (out_port !== 8'h7E) begin
            n_fail++;
            $display("FAIL outclear: got %h expected 7e", out_port);
        end
        do_read(3'd0);
        n_checks++;
        if (readdata !== 32'h0000_007E) begin
            n_fail++;
            $display("FAIL read_data: got %h expected 0000007e", readdata);
        end
    endtask

    task automatic test_ignored;
        do_write(3'd6, 32'hFFFF_FFFF);
        do_write(3'd1, 32'hFFFF_FFFF);
        do_write(3'd7, 32'h0000_0000);
        n_checks++;
        if (out_port !== 8'h7E) begin
            n_fail++;
            $display("FAIL ignored_write_out_port: got %h expected 7e", out_port);
        end
        for (int i = 0; i < 4; i++) begin
            logic [2:0] a;
            case (i)
                0:       a = 3'd1;
                1:       a = 3'd6;
                2:       a = 3'd4;
                default: a = 3'd5;
            endcase
            do_read(a);
            n_checks++;
            if (readdata !== 32'd0) begin
                n_fail++;
                $display("FAIL read_unmapped_%0d: got %h expected 00000000", a, readdata);
            end
        end
    endtask

`ifdef SOC_SYSTEM_LED_PIO_BLINK_EN
    task automatic test_blink;
        logic [7:0] exp;
        do_write(3'd0, 32'h0000_0000);
        do_write(3'd2, 32'hFFFF_FF03);
        do_write(3'd3, 32'h0000_0004);
        n_checks++;
        if (out_port !== 8'h00) begin
            n_fail++;
            $display("FAIL blink_start: got %h expected 00", out_port);
        end
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            exp = (((k / 5) % 2) == 1) ? 8'h03 : 8'h00;
            n_checks++;
            if (out_port !== exp) begin
                n_fail++;
                $display("FAIL blink_cycle_%0d: got %h expected %h", k, out_port, exp);
            end
        end
        do_read(3'd2);
        n_checks++;
        if (readdata !== 32'h0000_0003) begin
            n_fail++;
            $display("FAIL read_mask: got %h expected 00000003", readdata);
        end
        do_write(3'd3, 32'h0000_0000);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_port !== 8'h00) begin
                n_fail++;
                $display("FAIL blink_off_%0d: got %h expected 00", k, out_port);
            end
        end
    endtask

    task automatic test_wrap_write;
        logic [7:0] exp;
        do_write(3'd3, 32'h0000_0004);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
        end
        do_write(3'd3, 32'hFF00_0004);
        n_checks++;
        if (out_port !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_write_no_toggle: got %h expected 00", out_port);
        end
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            exp = (k == 5) ? 8'h03 : 8'h00;
            n_checks++;
            if (out_port !== exp) begin
                n_fail++;
                $display("FAIL wrap_restart_%0d: got %h expected %h", k, out_port, exp);
            end
        end
        do_read(3'd3);
        n_checks++;
        if (readdata !== 32'h0000_0004) begin
            n_fail++;
            $display("FAIL read_period: got %h expected 00000004", readdata);
        end
    endtask
`else
    task automatic test_blink_disabled;
        do_write(3'd2, 32'h0000_00FF);
        do_write(3'd3, 32'h0000_0001);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_port !== 8'h7E) begin
                n_fail++;
                $display("FAIL disabled_out_port_%0d: got %h expected 7e", k, out_port);
            end
        end
        do_read(3'd2);
        n_checks++;
        if (readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL disabled_read_addr2: got %h expected 00000000", readdata);
        end
        do_read(3'd3);
        n_checks++;
        if (readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL disabled_read_addr3: got %h expected 00000000", readdata);
        end
    endtask
`endif

    task automatic test_reset_mid;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_port !== 8'hA5) begin
            n_fail++;
            $display("FAIL mid_reset_out_port: got %h expected a5", out_port);
        end
        n_checks++;
        if (readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset_readdata: got %h expected 00000000", readdata);
        end
        @(negedge clk);
        reset      = 1'b0;
        address    = 3'd0;
        writedata  = 32'h0000_003C;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        n_checks++;
        if (out_port !== 8'h3C) begin
            n_fail++;
            $display("FAIL first_write_after_reset: got %h expected 3c", out_port);
        end
        do_write(3'd0, 32'h0000_0011);
        n_checks++;
        if (out_port !== 8'h11) begin
            n_fail++;
            $display("FAIL back_to_back_write: got %h expected 11", out_port);
        end
`ifdef SOC_SYSTEM_LED_PIO_BLINK_EN
        do_write(3'd2, 32'h0000_00FF);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_port !== 8'h11) begin
                n_fail++;
                $display("FAIL no_blink_after_reset_%0d: got %h expected 11", k, out_port);
            end
        end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_set_clear();
        test_ignored();
`ifdef SOC_SYSTEM_LED_PIO_BLINK_EN
        test_blink();
        test_wrap_write();
`else
        test_blink_disabled();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
